// File: rtl/mem_pkg.sv
// Shared constants for the write sequencer and the 64-bit x 8-entry Memory block.
// Holds the FSM state encodings and the default data/address widths.
// Ports: none (package).
package mem_pkg;

    // Default geometry; must agree with the Memory block this sequencer feeds.
    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 3;

    // Sequencer FSM state encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mem_addr_counter.sv
// Loadable wrapping address counter plus down-counter of words remaining in a burst.
// Ports: clk/rst; load_i latches load_addr_i/load_len_i; inc_i advances one word;
//        addr_o is the current write address, last_o flags exactly one word remaining.
module mem_addr_counter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q,  rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = load_addr_i;
            rem_d  = load_len_i;
        end else if (inc_i) begin
            // Natural overflow of the ADDR_WIDTH-bit add gives the modulo-depth wrap.
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1});

endmodule

// File: rtl/mem_write_sequencer.sv
// Burst write sequencer: takes (startAddr, len), consumes a valid/ready stream and
// issues one registered memory write per accepted word at consecutive wrapping addresses.
// Ports: clk/rst; start/startAddr/len command; inValid/inData/inReady stream;
//        memAddr/memData/memWR to the Memory write port; busy/done/startErr status.
module mem_write_sequencer
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  inValid,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  inReady,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memData,
    output logic                  memWR,
    output logic                  busy,
    output logic                  done,
    output logic                  startErr
);

    logic [1:0]            state_q, state_d;
    logic                  mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  start_err_q;

    logic                  xfer;
    logic                  load;
    logic                  last;
    logic [ADDR_WIDTH-1:0] cnt_addr;

    // Ready depends on state alone so upstream never sees a comb path from inValid.
    assign inReady = (state_q == ST_WRITE);
    assign xfer    = inValid && inReady;
    // A zero-length burst skips WRITE entirely, so there is nothing to load.
    assign load    = (state_q == ST_IDLE) && start && (len != '0);

    mem_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .inc_i       (xfer),
        .load_addr_i (startAddr),
        .load_len_i  (len),
        .addr_o      (cnt_addr),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (xfer && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_wr_q    <= xfer;
            // Address/data hold through bubbles; only WR drops.
            if (xfer) begin
                mem_addr_q <= cnt_addr;
                mem_data_q <= inData;
            end
            // DONE counts as busy, so a start there is also flagged.
            start_err_q <= start && (state_q != ST_IDLE);
        end
    end

    assign memWR    = mem_wr_q;
    assign memAddr  = mem_addr_q;
    assign memData  = mem_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign startErr = start_err_q;

endmodule

// File: tb/tb_mem_write_sequencer.sv
// Self-checking bench for mem_write_sequencer with a word-level burst model
// and a behavioural 8-entry memory fed from the sequencer's write port.
// Ports: none (top-level bench).
module tb_mem_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  startAddr;
    logic [3:0]  len;
    logic        inValid;
    logic [63:0] inData;
    logic        inReady;
    logic [2:0]  memAddr;
    logic [63:0] memData;
    logic        memWR;
    logic        busy;
    logic        done;
    logic        startErr;

    int checks = 0;
    int errors = 0;

    logic [63:0] tb_mem [8] = '{default: 64'd0};
    int          wcnt   [8] = '{default: 0};
    int          snap   [8];

    mem_write_sequencer #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .startAddr (startAddr),
        .len       (len),
        .inValid   (inValid),
        .inData    (inData),
        .inReady   (inReady),
        .memAddr   (memAddr),
        .memData   (memData),
        .memWR     (memWR),
        .busy      (busy),
        .done      (done),
        .startErr  (startErr)
    );

    always #5 clk = ~clk;

    // Stand-in for the Memory block: writes on the rising edge when WR is high.
    always @(posedge clk) begin
        if (memWR) begin
            tb_mem[memAddr] <= memData;
            wcnt[memAddr]   <= wcnt[memAddr] + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < 8; i++) snap[i] = wcnt[i];
    endtask

    // Runs one burst from IDLE. vmode: 0 = valid always, 1 = pattern bits, 2 = random.
    // Data words are base+index unless vmode==2 (random). inject issues a second start
    // mid-burst, which must only raise startErr.
    task automatic burst(input logic [2:0] a, input logic [3:0] n, input int vmode,
                         input logic [31:0] pat, input logic [63:0] base, input bit inject);
        int          sent;
        int          cyc;
        bit          prev;
        bit          v;
        bit          exp_err;
        bit          injected;
        logic [2:0]  ea;
        logic [63:0] ed;
        logic [63:0] d;
        ea = 3'd0;
        ed = 64'd0;
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_ready", {63'd0, inReady}, 64'd0);
        start     = 1'b1;
        startAddr = a;
        len       = n;
        inValid   = 1'($urandom % 2);
        inData    = {$urandom, $urandom};
        @(negedge clk);
        start     = 1'b0;
        startAddr = 3'($urandom);
        len       = 4'($urandom);
        inValid   = 1'b0;
        if (n == 4'd0) begin
            chk("len0_busy", {63'd0, busy}, 64'd1);
            chk("len0_done", {63'd0, done}, 64'd1);
            chk("len0_ready", {63'd0, inReady}, 64'd0);
            chk("len0_wr", {63'd0, memWR}, 64'd0);
            @(negedge clk);
            chk("len0_busy_after", {63'd0, busy}, 64'd0);
            chk("len0_done_after", {63'd0, done}, 64'd0);
            chk("len0_wr_after", {63'd0, memWR}, 64'd0);
            return;
        end
        sent = 0; cyc = 0; prev = 1'b0; exp_err = 1'b0; injected = 1'b0;
        while (sent < int'(n) && cyc < 200) begin
            chk("wr_busy", {63'd0, busy}, 64'd1);
            chk("wr_ready", {63'd0, inReady}, 64'd1);
            chk("wr_done", {63'd0, done}, 64'd0);
            chk("wr_strobe", {63'd0, memWR}, {63'd0, prev});
            chk("wr_starterr", {63'd0, startErr}, {63'd0, exp_err});
            if (prev) begin
                chk("wr_addr", {61'd0, memAddr}, {61'd0, ea});
                chk("wr_data", memData, ed);
            end
            exp_err = 1'b0;
            start   = 1'b0;
            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = pat[cyc % 32];
            else                 v = 1'($urandom % 2);
            d = (vmode == 2) ? {$urandom, $urandom} : base + 64'(sent);
            inValid = v;
            inData  = d;
            if (inject && !injected && sent == 1) begin
                start     = 1'b1;
                startAddr = 3'd0;
                len       = 4'd1;
                injected  = 1'b1;
                exp_err   = 1'b1;
            end
            if (v) begin
                ea = a + sent[2:0];
                ed = d;
                sent++;
            end
            prev = v;
            @(negedge clk);
            cyc++;
        end
        if (sent < int'(n)) chk("burst_timeout", 64'(sent), 64'(n));
        start   = 1'b0;
        inValid = 1'b0;
        chk("end_done", {63'd0, done}, 64'd1);
        chk("end_busy", {63'd0, busy}, 64'd1);
        chk("end_ready", {63'd0, inReady}, 64'd0);
        chk("end_wr", {63'd0, memWR}, 64'd1);
        chk("end_addr", {61'd0, memAddr}, {61'd0, ea});
        chk("end_data", memData, ed);
        chk("end_starterr", {63'd0, startErr}, {63'd0, exp_err});
        @(negedge clk);
        chk("post_done", {63'd0, done}, 64'd0);
        chk("post_busy", {63'd0, busy}, 64'd0);
        chk("post_wr", {63'd0, memWR}, 64'd0);
        chk("post_starterr", {63'd0, startErr}, 64'd0);
    endtask

    initial begin
        logic [2:0]  ra;
        logic [3:0]  rn;
        logic [2:0]  idx;
        rst = 1'b1; start = 1'b0; startAddr = 3'd0; len = 4'd0;
        inValid = 1'b0; inData = 64'd0;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_wr", {63'd0, memWR}, 64'd0);
        chk("rst_addr", {61'd0, memAddr}, 64'd0);
        chk("rst_data", memData, 64'd0);
        chk("rst_starterr", {63'd0, startErr}, 64'd0);
        chk("rst_ready", {63'd0, inReady}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic burst: addresses 2,3,4 with A,B,C
        burst(3'd2, 4'd3, 0, 32'd0, 64'hA, 1'b0);
        chk("mem2", tb_mem[2], 64'hA);
        chk("mem3", tb_mem[3], 64'hB);
        chk("mem4", tb_mem[4], 64'hC);

        // Wrap and full depth from address 6
        take_snap();
        burst(3'd6, 4'd8, 0, 32'd0, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idx = 3'd6 + 3'(i);
            chk("full_cnt", 64'(wcnt[idx] - snap[idx]), 64'd1);
            chk("full_data", tb_mem[idx], 64'(i));
        end

        // Bubbles: valid pattern 1,0,0,1,1,0,1
        take_snap();
        burst(3'd5, 4'd4, 1, 32'b1011001, 64'h100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idx = 3'd5 + 3'(i);
            chk("bub_cnt", 64'(wcnt[idx] - snap[idx]), 64'd1);
            chk("bub_data", tb_mem[idx], 64'h100 + 64'(i));
        end

        // Zero-length burst
        take_snap();
        burst(3'd3, 4'd0, 0, 32'd0, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) chk("len0_nowrite", 64'(wcnt[i] - snap[i]), 64'd0);

        // Start while busy: must not disturb burst at 3..6 nor write address 0
        take_snap();
        burst(3'd3, 4'd4, 0, 32'd0, 64'h200, 1'b1);
        chk("busy_start_no_addr0", 64'(wcnt[0] - snap[0]), 64'd0);
        chk("busy_start_mem6", tb_mem[6], 64'h203);

        // Reset mid-burst after 2 of 5 words
        start = 1'b1; startAddr = 3'd0; len = 4'd5;
        @(negedge clk);
        start = 1'b0; inValid = 1'b1; inData = 64'h11;
        @(negedge clk);
        inData = 64'h12;
        @(negedge clk);
        rst = 1'b1; inData = 64'h13;
        @(negedge clk);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_wr", {63'd0, memWR}, 64'd0);
        chk("mid_rst_ready", {63'd0, inReady}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_addr", {61'd0, memAddr}, 64'd0);
        rst = 1'b0; inValid = 1'b0;
        @(negedge clk);
        chk("mid_rst_done2", {63'd0, done}, 64'd0);
        chk("mid_rst_busy2", {63'd0, busy}, 64'd0);
        burst(3'd1, 4'd1, 0, 32'd0, 64'h77, 1'b0);
        chk("after_rst_mem1", tb_mem[1], 64'h77);

        // Randomized bursts with random valid gaps and data
        for (int k = 0; k < 12; k++) begin
            ra = 3'($urandom);
            rn = 4'($urandom_range(0, 8));
            take_snap();
            burst(ra, rn, 2, 32'd0, 64'd0, 1'b0);
            for (int i = 0; i < 8; i++) begin
                idx = 3'(i);
                chk("rand_cnt", 64'(wcnt[idx] - snap[idx]),
                    (3'(idx - ra) < rn) ? 64'd1 : 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
